// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among
// NREQ byte-producing requesters.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enable          allow new grants (a byte in flight always completes)
//   req, req_data   per-requester level request and byte (byte i at [8i+7:8i])
//   gnt             one-hot single-cycle pulse: byte from that requester captured
//   busy            high whenever the scheduler is not idle
//   newd, dintx     start strobe and byte to the transmitter
//   en_tx           registered copy of enable
//   donetx          transmitter completion level
//   done_pulse      one-cycle pulse when a byte completes
//   done_id         requester index for done_pulse / timeout_pulse
//   timeout_pulse   one-cycle pulse when a byte is aborted
//   timeout_err     sticky abort flag, cleared only by rst
module uart_tx_sched #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    output logic                 newd,
    output logic [7:0]           dintx,
    output logic                 en_tx,
    input  logic                 donetx,
    output logic                 done_pulse,
    output logic [2:0]           done_id,
    output logic                 timeout_pulse,
    output logic                 timeout_err
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   sel;
    logic [LW-1:0]   cand;
    logic            found;
    logic [CW-1:0]   cnt;
    logic            donetx_q;
    logic            rise;

    // Search starts one past the most recent grant, so the last winner
    // ends up with the lowest priority.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = LW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign rise = donetx & ~donetx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last          <= LAST_RST;
            cnt           <= '0;
            donetx_q      <= 1'b0;
            gnt           <= '0;
            busy          <= 1'b0;
            newd          <= 1'b0;
            dintx         <= 8'h00;
            en_tx         <= 1'b0;
            done_pulse    <= 1'b0;
            done_id       <= 3'd0;
            timeout_pulse <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            gnt           <= '0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
            en_tx         <= enable;
            donetx_q      <= donetx;
            case (state)
                IDLE: begin
                    if (enable && found) begin
                        state <= SEND;
                        busy  <= 1'b1;
                        gnt   <= NREQ'(1) << sel;
                        dintx <= req_data[int'(sel)*8 +: 8];
                        newd  <= 1'b1;
                        last  <= sel;
                        cnt   <= '0;
                    end
                end
                SEND: begin
                    // A completion on the final wait cycle beats the abort.
                    if (rise) begin
                        state      <= DRAIN;
                        newd       <= 1'b0;
                        done_pulse <= 1'b1;
                        done_id    <= 3'(last);
                    end else if (cnt == CNT_MAX) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        newd          <= 1'b0;
                        timeout_pulse <= 1'b1;
                        timeout_err   <= 1'b1;
                        done_id       <= 3'(last);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Wait out the completion level so it cannot finish the
                    // next byte.
                    if (!donetx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    newd  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched. Two instances share
// clock, reset and requests: dut_a (long timeout) for normal traffic and
// dut_b (TIMEOUT_CYCLES = 16) for abort behaviour. A behavioural model
// predicts every output of both instances each cycle.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        enable_b = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [31:0] req_data = 32'h0;
    logic        donetx = 1'b0;
    logic        donetx_b = 1'b0;

    logic [3:0]  gnt_a, gnt_b;
    logic        busy_a, busy_b, newd_a, newd_b, en_tx_a, en_tx_b;
    logic [7:0]  dintx_a, dintx_b;
    logic        done_pulse_a, done_pulse_b, timeout_pulse_a, timeout_pulse_b;
    logic        timeout_err_a, timeout_err_b;
    logic [2:0]  done_id_a, done_id_b;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sched #(.NREQ(4), .TIMEOUT_CYCLES(64)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .req_data(req_data),
        .gnt(gnt_a), .busy(busy_a), .newd(newd_a), .dintx(dintx_a), .en_tx(en_tx_a),
        .donetx(donetx), .done_pulse(done_pulse_a), .done_id(done_id_a),
        .timeout_pulse(timeout_pulse_a), .timeout_err(timeout_err_a)
    );

    uart_tx_sched #(.NREQ(4), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .enable(enable_b), .req(req), .req_data(req_data),
        .gnt(gnt_b), .busy(busy_b), .newd(newd_b), .dintx(dintx_b), .en_tx(en_tx_b),
        .donetx(donetx_b), .done_pulse(done_pulse_b), .done_id(done_id_b),
        .timeout_pulse(timeout_pulse_b), .timeout_err(timeout_err_b)
    );

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for a request, 1 byte handed to transmitter,
    // 2 byte finished but transmitter still reporting done.
    typedef struct packed {
        logic [1:0]  phase;
        logic [1:0]  owner;
        logic [31:0] waited;     // cycles the current byte has spent with newd high
        logic        prev_done;
        logic [3:0]  gnt;
        logic        busy;
        logic        newd;
        logic [7:0]  dintx;
        logic        en_tx;
        logic        done_pulse;
        logic [2:0]  done_id;
        logic        timeout_pulse;
        logic        timeout_err;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, logic r, logic en, logic [3:0] rq,
                                  logic [31:0] rd, logic dn, int tmo);
        mdl_t n;
        int   pick;
        n = m;
        n.gnt = 4'b0;
        n.done_pulse = 1'b0;
        n.timeout_pulse = 1'b0;
        if (r) begin
            n = '0;
            n.owner = 2'd3;
            return n;
        end
        n.en_tx = en;
        n.prev_done = dn;
        if (m.phase == 2'd0) begin
            if (en && rq != 4'b0) begin
                pick = -1;
                for (int k = 1; k <= 4; k++)
                    if (pick < 0 && rq[(int'(m.owner) + k) % 4]) pick = (int'(m.owner) + k) % 4;
                n.gnt = 4'b0001 << pick;
                n.dintx = rd[pick*8 +: 8];
                n.newd = 1'b1;
                n.busy = 1'b1;
                n.owner = 2'(pick);
                n.waited = 32'd1;
                n.phase = 2'd1;
            end
        end else if (m.phase == 2'd1) begin
            if (dn && !m.prev_done) begin
                n.newd = 1'b0;
                n.done_pulse = 1'b1;
                n.done_id = {1'b0, m.owner};
                n.phase = 2'd2;
            end else if (m.waited == 32'(tmo)) begin
                n.newd = 1'b0;
                n.busy = 1'b0;
                n.timeout_pulse = 1'b1;
                n.timeout_err = 1'b1;
                n.done_id = {1'b0, m.owner};
                n.phase = 2'd0;
            end else begin
                n.waited = m.waited + 32'd1;
            end
        end else begin
            if (!dn) begin
                n.busy = 1'b0;
                n.phase = 2'd0;
            end
        end
        return n;
    endfunction

    mdl_t ma = '0;
    mdl_t mb = '0;

    always @(posedge clk) begin
        ma <= step(ma, rst, enable, req, req_data, donetx, 64);
        mb <= step(mb, rst, enable_b, req, req_data, donetx_b, 16);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("a.gnt", 32'(gnt_a), 32'(ma.gnt));
            check("a.busy", 32'(busy_a), 32'(ma.busy));
            check("a.newd", 32'(newd_a), 32'(ma.newd));
            check("a.dintx", 32'(dintx_a), 32'(ma.dintx));
            check("a.en_tx", 32'(en_tx_a), 32'(ma.en_tx));
            check("a.done_pulse", 32'(done_pulse_a), 32'(ma.done_pulse));
            check("a.done_id", 32'(done_id_a), 32'(ma.done_id));
            check("a.timeout_pulse", 32'(timeout_pulse_a), 32'(ma.timeout_pulse));
            check("a.timeout_err", 32'(timeout_err_a), 32'(ma.timeout_err));
            check("b.gnt", 32'(gnt_b), 32'(mb.gnt));
            check("b.busy", 32'(busy_b), 32'(mb.busy));
            check("b.newd", 32'(newd_b), 32'(mb.newd));
            check("b.dintx", 32'(dintx_b), 32'(mb.dintx));
            check("b.en_tx", 32'(en_tx_b), 32'(mb.en_tx));
            check("b.done_pulse", 32'(done_pulse_b), 32'(mb.done_pulse));
            check("b.done_id", 32'(done_id_b), 32'(mb.done_id));
            check("b.timeout_pulse", 32'(timeout_pulse_b), 32'(mb.timeout_pulse));
            check("b.timeout_err", 32'(timeout_err_b), 32'(mb.timeout_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input bit use_b, output int idx);
        logic [3:0] g;
        idx = -1;
        for (int n = 0; n < 100 && idx < 0; n++) begin
            tick();
            g = use_b ? gnt_b : gnt_a;
            for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        end
        if (idx < 0) check("gnt_wait_expired", 32'd0, 32'd1);
    endtask

    // Called while dut_a is in SEND: raise donetx after d cycles, hold h edges.
    task automatic serve_a(input int d, input int h);
        repeat (d) tick();
        donetx = 1'b1;
        repeat (h) tick();
        donetx = 1'b0;
        tick();
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int exp_bytes [5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10};

    initial begin
        int idx;
        int bad;
        int n;
        int order [5];
        int bytes [5];

        // reset state
        tick();
        chk_on = 1'b1;
        check("rst.busy", 32'(busy_a), 32'd0);
        check("rst.newd", 32'(newd_a), 32'd0);
        check("rst.dintx", 32'(dintx_a), 32'd0);
        rst = 1'b0;

        // single byte from channel 2
        enable = 1'b1;
        req_data = 32'h13_A5_11_10;
        req = 4'b0100;
        wait_gnt(1'b0, idx);
        check("single.gnt", 32'(gnt_a), 32'h4);
        check("single.dintx", 32'(dintx_a), 32'hA5);
        req = 4'b0;
        bad = 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (!newd_a || dintx_a != 8'hA5 || gnt_a != 4'b0) bad++;
        end
        check("single.hold", 32'(bad), 32'd0);
        donetx = 1'b1;
        tick();
        check("single.done_pulse", 32'(done_pulse_a), 32'd1);
        check("single.done_id", 32'(done_id_a), 32'd2);
        check("single.newd_low", 32'(newd_a), 32'd0);
        donetx = 1'b0;
        tick();
        tick();
        check("single.idle", 32'(busy_a), 32'd0);

        // fairness: everyone requests continuously
        do_reset();
        req_data = 32'h13_12_11_10;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(1'b0, idx);
            order[i] = idx;
            bytes[i] = int'(dintx_a);
            if (i == 4) req = 4'b0;
            serve_a(5, 1);
        end
        for (int i = 0; i < 5; i++) begin
            check("fair.order", 32'(order[i]), 32'(exp_order[i]));
            check("fair.byte", 32'(bytes[i]), 32'(exp_bytes[i]));
        end

        // rotation: after channel 1, channel 3 outranks channel 0
        do_reset();
        req = 4'b0010;
        wait_gnt(1'b0, idx);
        check("rot.first", 32'(idx), 32'd1);
        req = 4'b0;
        serve_a(3, 1);
        req = 4'b1001;
        wait_gnt(1'b0, idx);
        check("rot.second", 32'(idx), 32'd3);
        req = 4'b0001;
        serve_a(3, 1);
        wait_gnt(1'b0, idx);
        check("rot.third", 32'(idx), 32'd0);
        req = 4'b0;
        serve_a(3, 1);

        // enable gating, and enable dropping mid-byte
        do_reset();
        enable = 1'b0;
        req = 4'b0001;
        repeat (5) tick();
        check("en.no_grant", 32'(busy_a), 32'd0);
        enable = 1'b1;
        wait_gnt(1'b0, idx);
        check("en.grant", 32'(idx), 32'd0);
        req = 4'b0;
        enable = 1'b0;
        repeat (4) tick();
        donetx = 1'b1;
        tick();
        check("en.complete", 32'(done_pulse_a), 32'd1);
        donetx = 1'b0;
        tick();
        enable = 1'b1;

        // stale done level keeps the scheduler in DRAIN
        do_reset();
        req = 4'b0001;
        wait_gnt(1'b0, idx);
        req = 4'b0;
        repeat (5) tick();
        donetx = 1'b1;
        req = 4'b0010;
        tick();
        n = (busy_a && !newd_a) ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (busy_a && !newd_a && gnt_a == 4'b0) n++;
        end
        check("stale.drain_cycles", 32'(n), 32'd20);
        donetx = 1'b0;
        tick();
        check("stale.idle_busy", 32'(busy_a), 32'd0);
        check("stale.idle_newd", 32'(newd_a), 32'd0);
        tick();
        check("stale.next_gnt", 32'(gnt_a), 32'h2);
        req = 4'b0;
        serve_a(3, 1);

        // timeout on the short-timeout instance
        do_reset();
        enable = 1'b0;
        enable_b = 1'b1;
        req = 4'b0001;
        wait_gnt(1'b1, idx);
        req = 4'b0;
        enable_b = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && newd_b; i++) begin
            n++;
            tick();
        end
        check("tmo.newd_cycles", 32'(n), 32'd16);
        check("tmo.pulse", 32'(timeout_pulse_b), 32'd1);
        check("tmo.err", 32'(timeout_err_b), 32'd1);
        check("tmo.busy", 32'(busy_b), 32'd0);
        tick();
        check("tmo.pulse_end", 32'(timeout_pulse_b), 32'd0);
        check("tmo.err_sticky", 32'(timeout_err_b), 32'd1);

        // tie: rise on the last wait cycle completes normally
        do_reset();
        enable_b = 1'b1;
        req = 4'b0010;
        wait_gnt(1'b1, idx);
        req = 4'b0;
        enable_b = 1'b0;
        repeat (15) tick();
        check("tie.still_send", 32'(newd_b), 32'd1);
        donetx_b = 1'b1;
        tick();
        check("tie.done", 32'(done_pulse_b), 32'd1);
        check("tie.no_tmo", 32'(timeout_pulse_b), 32'd0);
        check("tie.no_err", 32'(timeout_err_b), 32'd0);
        check("tie.done_id", 32'(done_id_b), 32'd1);
        donetx_b = 1'b0;
        tick();
        tick();

        // reset mid-SEND
        enable = 1'b1;
        req = 4'b0100;
        wait_gnt(1'b0, idx);
        req = 4'b1111;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst2.gnt", 32'(gnt_a), 32'd0);
        check("rst2.busy", 32'(busy_a), 32'd0);
        check("rst2.newd", 32'(newd_a), 32'd0);
        check("rst2.dintx", 32'(dintx_a), 32'd0);
        check("rst2.en_tx", 32'(en_tx_a), 32'd0);
        check("rst2.done_id", 32'(done_id_a), 32'd0);
        rst = 1'b0;
        wait_gnt(1'b0, idx);
        check("rst2.prio0", 32'(idx), 32'd0);
        req = 4'b0;
        serve_a(3, 1);
        tick();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
